// File: rtl/cam_pkg.sv
// Shared types and pixel conversion helpers
// for the camera capture engine.
package cam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_CAPT = 2'd2
  } state_e;

  typedef enum logic {
    FMT_RGB565 = 1'b0,
    FMT_YUV    = 1'b1
  } fmt_e;

  localparam int RGB_W  = 12;
  localparam int LUMA_W = 8;

  function automatic logic [RGB_W-1:0] rgb565_to_444(
    input logic [7:0] hi,
    input logic [7:0] lo
  );
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

  function automatic logic [LUMA_W-1:0] yuv_luma(
    input logic [7:0] hi
  );
    return hi;
  endfunction

endpackage

// File: rtl/cam_pix_pack.sv
// Byte-pair assembler: holds the first byte of a pixel
// and converts the pair to the frame-buffer pixel width.
module cam_pix_pack
  import cam_pkg::*;
#(
  parameter int PIX_W = 12
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             stb,
  input  logic             fmt,
  input  logic [7:0]       data,
  output logic             vld,
  output logic [PIX_W-1:0] pix
);

  logic             phase;
  logic [7:0]       hi;
  logic [11:0]      rgb;
  logic [7:0]       luma;
  logic [PIX_W-1:0] rgb_x;
  logic [PIX_W-1:0] luma_x;

  // byte phase toggles per accepted byte; first byte is held
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase <= 1'b0;
      hi    <= 8'h00;
    end else if (clr) begin
      phase <= 1'b0;
    end else if (stb) begin
      if (!phase) hi <= data;
      phase <= ~phase;
    end
  end

  assign rgb  = rgb565_to_444(hi, data);
  assign luma = yuv_luma(hi);

  if (PIX_W >= 12) begin : g_wide
    assign rgb_x  = PIX_W'(rgb) << (PIX_W - 12);
    assign luma_x = PIX_W'(luma) << (PIX_W - 8);
  end else begin : g_narrow
    assign rgb_x  = rgb[11 -: PIX_W];
    assign luma_x = PIX_W'(luma) << (PIX_W - 8);
  end

  assign vld = stb & phase;
  assign pix = (fmt == FMT_YUV) ? luma_x : rgb_x;

endmodule

// File: rtl/cam_capture.sv
// Camera capture engine: frames the OV pixel bus, decimates
// and writes pixels linearly into the frame memory.
module cam_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int DECIM    = 2,
  parameter int PIX_W    = 12,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pix_stb,
  input  logic              cam_vsynk,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  input  logic              enable,
  input  logic              fmt,
  input  logic              snap,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [1:0]        err
);

  localparam int PW   = $clog2(H_ACTIVE + 1);
  localparam int LW   = $clog2(V_ACTIVE + 2);
  localparam int NPIX = (H_ACTIVE / DECIM) * (V_ACTIVE / DECIM);

  localparam logic [PW-1:0] PIX_END  = PW'(H_ACTIVE);
  localparam logic [LW-1:0] LINE_END = LW'(V_ACTIVE);
  localparam logic [LW-1:0] LINE_OVR = LW'(V_ACTIVE + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NPIX - 1);

  state_e            state;
  logic              oneshot;
  logic [PW-1:0]     pix_cnt;
  logic [LW-1:0]     line_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              href_q;
  logic              vs_q;
  logic              en_q;

  logic              capt;
  logic              href_fall;
  logic              vs_rise;
  logic              vs_fall;
  logic              en_rise;
  logic              byte_stb;
  logic              pack_clr;
  logic              pix_vld;
  logic [PIX_W-1:0]  pix;
  logic              keep;
  logic [1:0]        err_set;
  logic              err_clr;

  assign capt      = (state == ST_CAPT);
  assign href_fall = pix_stb & href_q & ~cam_href;
  assign vs_rise   = cam_vsynk & ~vs_q;
  assign vs_fall   = ~cam_vsynk & vs_q;
  assign en_rise   = enable & ~en_q;
  assign byte_stb  = pix_stb & cam_href & capt;
  assign pack_clr  = ((state == ST_ARM) & vs_fall)
                   | (capt & href_fall);
  assign err_clr   = en_rise | (snap & (state == ST_IDLE));

  cam_pix_pack #(
    .PIX_W (PIX_W)
  ) u_pack (
    .clk  (clk),
    .rstn (rstn),
    .clr  (pack_clr),
    .stb  (byte_stb),
    .fmt  (fmt),
    .data (cam_data),
    .vld  (pix_vld),
    .pix  (pix)
  );

  // keep/drop decision and error sources for the current cycle
  always_comb begin
    keep    = 1'b0;
    err_set = 2'b00;
    if (pix_vld) begin
      if (pix_cnt >= PIX_END) begin
        err_set[0] = 1'b1;
      end else if (line_cnt >= LINE_END) begin
        err_set[1] = 1'b1;
      end else begin
        keep = (DECIM == 1) || (!pix_cnt[0] && !line_cnt[0]);
      end
    end
    if (capt && href_fall && pix_cnt != PIX_END)
      err_set[0] = 1'b1;
    if (capt && vs_rise && line_cnt != LINE_END)
      err_set[1] = 1'b1;
  end

  // previous-value registers for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      href_q <= 1'b0;
      vs_q   <= 1'b0;
      en_q   <= 1'b0;
    end else begin
      vs_q <= cam_vsynk;
      en_q <= enable;
      if (pix_stb) href_q <= cam_href;
    end
  end

  // capture FSM with counters and registered write port
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      oneshot    <= 1'b0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      addr_cnt   <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= 16'd0;
      err        <= 2'b00;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      err        <= err_clr ? 2'b00 : (err | err_set);

      if (keep) begin
        wr_en   <= 1'b1;
        wr_addr <= addr_cnt;
        wr_data <= pix;
        if (addr_cnt != ADDR_MAX)
          addr_cnt <= addr_cnt + 1'b1;
      end

      if (pix_vld && pix_cnt != PIX_END)
        pix_cnt <= pix_cnt + 1'b1;

      if (capt && href_fall) begin
        pix_cnt <= '0;
        if (line_cnt != LINE_OVR)
          line_cnt <= line_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          if (enable || snap) begin
            state   <= ST_ARM;
            busy    <= 1'b1;
            oneshot <= snap;
          end
        end
        ST_ARM: begin
          if (vs_fall) begin
            state    <= ST_CAPT;
            pix_cnt  <= '0;
            line_cnt <= '0;
            addr_cnt <= '0;
            wr_addr  <= '0;
          end else if (!enable && !oneshot) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_CAPT: begin
          if (vs_rise) begin
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 16'd1;
            oneshot    <= 1'b0;
            if (enable && !oneshot) begin
              state <= ST_ARM;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench: two capture engines (full rate and 2:1
// decimated) on one small camera bus, scoreboarded writes.
module tb_cam_capture;

  localparam int H = 8;
  localparam int V = 6;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       pix_stb = 1'b0;
  logic       cam_vsynk = 1'b1;
  logic       cam_href = 1'b0;
  logic [7:0] cam_data = 8'h00;
  logic       enable = 1'b0;
  logic       fmt = 1'b0;
  logic       snap = 1'b0;

  logic        wr_en1, wr_en2;
  logic [5:0]  wr_addr1;
  logic [3:0]  wr_addr2;
  logic [11:0] wr_data1, wr_data2;
  logic        frame_done1, frame_done2;
  logic        busy1, busy2;
  logic [15:0] frame_cnt1, frame_cnt2;
  logic [1:0]  err1, err2;

  int checks = 0;
  int errors = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  int nwr1 = 0;
  int nwr2 = 0;
  int nfd = 0;
  int max1 = 0;
  int m_line, m_a1, m_a2;
  bit m_on;
  bit pat;

  always #5 clk = ~clk;

  cam_capture #(
    .H_ACTIVE (H), .V_ACTIVE (V), .DECIM (1),
    .PIX_W (12), .ADDR_W (6)
  ) u_d1 (
    .clk (clk), .rstn (rstn), .pix_stb (pix_stb),
    .cam_vsynk (cam_vsynk), .cam_href (cam_href),
    .cam_data (cam_data), .enable (enable), .fmt (fmt),
    .snap (snap), .wr_en (wr_en1), .wr_addr (wr_addr1),
    .wr_data (wr_data1), .frame_done (frame_done1),
    .busy (busy1), .frame_cnt (frame_cnt1), .err (err1)
  );

  cam_capture #(
    .H_ACTIVE (H), .V_ACTIVE (V), .DECIM (2),
    .PIX_W (12), .ADDR_W (4)
  ) u_d2 (
    .clk (clk), .rstn (rstn), .pix_stb (pix_stb),
    .cam_vsynk (cam_vsynk), .cam_href (cam_href),
    .cam_data (cam_data), .enable (enable), .fmt (fmt),
    .snap (snap), .wr_en (wr_en2), .wr_addr (wr_addr2),
    .wr_data (wr_data2), .frame_done (frame_done2),
    .busy (busy2), .frame_cnt (frame_cnt2), .err (err2)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] exp_pix(input logic f,
                                          input logic [7:0] hi,
                                          input logic [7:0] lo);
    if (f) return {hi, 4'h0};
    return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
  endfunction

  // write monitor: every write must match the model queue
  always @(negedge clk) begin
    if (wr_en1) begin
      nwr1++;
      if (int'(wr_addr1) > max1) max1 = int'(wr_addr1);
      if (q1.size() == 0) chk("d1_extra_wr", 1, 0);
      else chk("d1_wr", {16'(wr_addr1), 4'h0, wr_data1},
               q1.pop_front());
    end
    if (wr_en2) begin
      nwr2++;
      if (q2.size() == 0) chk("d2_extra_wr", 1, 0);
      else chk("d2_wr", {16'(wr_addr2), 4'h0, wr_data2},
               q2.pop_front());
    end
    if (frame_done1) nfd++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic hr);
    cam_data = b;
    cam_href = hr;
    pix_stb  = 1'b1;
    tick();
    pix_stb  = 1'b0;
    tick();
  endtask

  task automatic send_line(input int npix, input bit odd);
    for (int p = 0; p < npix; p++) begin
      logic [7:0] hi, lo;
      logic [11:0] px;
      bit k1;
      hi = pat ? {m_line[3:0], p[3:0]} : 8'hF8;
      lo = pat ? 8'(p * 17 + m_line * 3) : 8'h1F;
      px = exp_pix(fmt, hi, lo);
      k1 = m_on && p < H && m_line < V;
      if (k1) begin
        q1.push_back({16'(m_a1), 4'h0, px});
        m_a1++;
        if (p % 2 == 0 && m_line % 2 == 0) begin
          q2.push_back({16'(m_a2), 4'h0, px});
          m_a2++;
        end
      end
      send_byte(hi, 1'b1);
      cam_data = lo;
      pix_stb  = 1'b1;
      tick();
      chk("wr_latency", wr_en1, k1);
      pix_stb  = 1'b0;
      tick();
      chk("wr_pulse", wr_en1, 0);
    end
    if (odd) send_byte(8'h55, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    m_line++;
  endtask

  task automatic frame_start;
    cam_vsynk = 1'b1;
    tick();
    tick();
    cam_vsynk = 1'b0;
    tick();
    tick();
    m_line = 0;
    m_a1   = 0;
    m_a2   = 0;
    max1   = 0;
  endtask

  task automatic frame_end(input bit done, input int cnt);
    cam_vsynk = 1'b1;
    tick();
    chk("frame_done", frame_done1, done);
    chk("frame_cnt", frame_cnt1, cnt);
    tick();
    chk("frame_done_pulse", frame_done1, 0);
  endtask

  int n1, n2, nf;

  initial begin
    m_on = 1'b1;
    pat  = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", wr_en1, 0);
    chk("rst_wr_addr", wr_addr1, 0);
    chk("rst_wr_data", wr_data1, 0);
    chk("rst_frame_done", frame_done1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_frame_cnt", frame_cnt1, 0);
    chk("rst_err", err1, 0);
    rstn = 1'b1;
    tick();

    // frame A: constant RGB565 F8/1F, continuous mode
    enable = 1'b1;
    tick();
    chk("arm_busy", busy1, 1);
    n1 = nwr1; n2 = nwr2; nf = nfd;
    frame_start();
    chk("capt_busy", busy1, 1);
    repeat (V) send_line(H, 1'b0);
    frame_end(1'b1, 1);
    chk("A_n1", nwr1 - n1, H * V);
    chk("A_n2", nwr2 - n2, (H / 2) * (V / 2));
    chk("A_max1", max1, H * V - 1);
    chk("A_nfd", nfd - nf, 1);
    chk("A_err", err1, 0);
    chk("A_busy_rearm", busy1, 1);

    // frame B: patterned data, one short line with odd byte
    pat = 1'b1;
    n1 = nwr1; n2 = nwr2;
    frame_start();
    send_line(H, 1'b0);
    send_line(H, 1'b0);
    send_line(H - 1, 1'b1);
    repeat (V - 3) send_line(H, 1'b0);
    frame_end(1'b1, 2);
    chk("B_n1", nwr1 - n1, H * V - 1);
    chk("B_n2", nwr2 - n2, (H / 2) * (V / 2));
    chk("B_err1", err1, 2'b01);
    chk("B_err2", err2, 2'b01);
    chk("B_q1", q1.size(), 0);

    // single shot in YUV with enable low
    enable = 1'b0;
    tick();
    tick();
    chk("disarm_busy", busy1, 0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("snap_busy", busy1, 1);
    chk("snap_err_clr", err1, 0);
    fmt = 1'b1;
    n1 = nwr1;
    frame_start();
    repeat (V) send_line(H, 1'b0);
    frame_end(1'b1, 3);
    chk("C_n1", nwr1 - n1, H * V);
    chk("C_idle", busy1, 0);
    n1 = nwr1;
    m_on = 1'b0;
    frame_start();
    send_line(H, 1'b0);
    send_line(H, 1'b0);
    frame_end(1'b0, 3);
    chk("C2_no_wr", nwr1 - n1, 0);

    // over-long frame, enable dropped mid-frame, late snap
    fmt  = 1'b0;
    m_on = 1'b1;
    enable = 1'b1;
    tick();
    n1 = nwr1;
    frame_start();
    repeat (3) send_line(H, 1'b0);
    enable = 1'b0;
    repeat (V + 2 - 3) send_line(H, 1'b0);
    snap = 1'b1;
    tick();
    snap = 1'b0;
    chk("D_snap_ignored", err1, 2'b10);
    frame_end(1'b1, 4);
    chk("D_n1", nwr1 - n1, H * V);
    chk("D_max1", max1, H * V - 1);
    chk("D_err", err1, 2'b10);
    chk("D_idle", busy1, 0);
    chk("D_cnt2", frame_cnt2, 4);

    // reset while capturing
    enable = 1'b1;
    tick();
    frame_start();
    send_line(H, 1'b0);
    send_line(H, 1'b0);
    n1 = nwr1;
    #2 rstn = 1'b0;
    #1;
    chk("mrst_wr_en", wr_en1, 0);
    chk("mrst_wr_addr", wr_addr1, 0);
    chk("mrst_wr_data", wr_data1, 0);
    chk("mrst_busy", busy1, 0);
    chk("mrst_frame_cnt", frame_cnt1, 0);
    chk("mrst_err", err1, 0);
    enable = 1'b0;
    m_on = 1'b0;
    tick();
    send_line(H, 1'b0);
    rstn = 1'b1;
    tick();
    send_line(H, 1'b0);
    chk("mrst_no_wr", nwr1 - n1, 0);
    chk("mrst_idle", busy1, 0);
    chk("end_q1", q1.size(), 0);
    chk("end_q2", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_capture.md
# cam_capture

Parametrised camera capture engine for the OV-style parallel pixel bus (vsync/href/8-bit data). It assembles byte pairs into pixels, optionally decimates 2:1 in each axis, converts to the frame-buffer pixel width and generates linear write addresses/strobes for the on-chip frame memory read by the VGA block. It replaces the free-running test-pattern writer in the top level and adds frame framing, single-shot capture, error flags and a frame counter for the MicroBlaze register block.

## Interface
- `H_ACTIVE`, 640: camera pixels per line (pixel = 2 bytes).
- `V_ACTIVE`, 480: camera lines per frame.
- `DECIM`, 2: 1 = every pixel, 2 = keep even pixel of even line only.
- `PIX_W`, 12: output pixel width; 12 = RGB444, 8 = luma.
- `ADDR_W`, 19: write address width; must satisfy 2^ADDR_W ≥ (H_ACTIVE/DECIM)·(V_ACTIVE/DECIM).
- `clk` in 1: system clock; all logic on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `pix_stb` in 1: one-cycle strobe marking a valid `cam_data` sample (pclk edge detected upstream in `clk` domain).
- `cam_vsynk` in 1: frame sync, high during vertical blanking; sampled on `pix_stb` and also every cycle.
- `cam_href` in 1: line valid; sampled only on `pix_stb`.
- `cam_data` in 8: pixel byte, sampled only on `pix_stb`.
- `enable` in 1: continuous capture when high.
- `fmt` in 1: 0 = RGB565 byte pairs, 1 = YUV422 (Y taken from first byte).
- `snap` in 1: one-cycle request to capture exactly one frame.
- `wr_en` out 1: frame-memory write strobe.
- `wr_addr` out ADDR_W: write address.
- `wr_data` out PIX_W: pixel data.
- `frame_done` out 1: one-cycle pulse at end of each captured frame.
- `busy` out 1: high in ARM and CAPT.
- `frame_cnt` out 16: captured-frame counter, wraps.
- `err` out 2: sticky; [0] short/long line, [1] short/long frame; cleared by `enable` rising or `snap`.

## Operation
- FSM states IDLE, ARM, CAPT.
- IDLE → ARM when `enable` = 1 or `snap` = 1; a `snap` latches a one-shot flag.
- ARM waits for a `cam_vsynk` falling edge (1→0); then CAPT with line/pixel counters, byte phase and `wr_addr` cleared.
- CAPT: on `pix_stb` with `cam_href` = 1, phase 0 stores byte hi; phase 1 forms pixel {hi, data}. RGB565 → RGB444 = {hi[7:4], hi[2:0],data[7], data[4:1]}; YUV → hi[7:0] (upper PIX_W bits, zero-padded if PIX_W > 8).
- Pixel kept when DECIM = 1, or when pixel_cnt[0] = 0 and line_cnt[0] = 0 for DECIM = 2. Kept pixel → `wr_en`, `wr_addr` post-increments.
- `cam_href` falling edge ends a line: pixel_cnt ≠ H_ACTIVE sets err[0]; a half pixel (phase 1 pending) is discarded; line_cnt increments; phase reset.
- Pixels beyond H_ACTIVE in a line and lines beyond V_ACTIVE are dropped (no write) and set err[0]/err[1] respectively.
- `cam_vsynk` rising in CAPT ends the frame: `frame_done` pulse, `frame_cnt` +1, line_cnt ≠ V_ACTIVE sets err[1]. Next state: ARM if `enable` = 1 and no one-shot pending, else IDLE (one-shot flag cleared).
- `wr_addr` saturates at the last legal address; it never wraps into frame start.
- `enable` dropping mid-frame: current frame completes, then IDLE.
- `snap` while busy: ignored.

## Timing
- Reset: state IDLE, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `frame_done` 0, `busy` 0, `frame_cnt` 0, `err` 0, all internal counters/flags 0.
- Write latency: `wr_en`/`wr_addr`/`wr_data` registered, valid the cycle after the second-byte `pix_stb`; `wr_en` high exactly one cycle.
- `frame_done` high one cycle, the cycle after vsync rise is detected; `frame_cnt` updates in that same cycle.
- `busy` registered with state.
- Edge detectors use registered previous values; `cam_href` edge is evaluated at `pix_stb`, `cam_vsynk` edge every cycle.
- Simultaneous last-pixel write and vsync rise: write is issued, then frame ends.

## Structure
- Package `cam_pkg`: state encoding, format codes (FMT_RGB565, FMT_YUV), `rgb565_to_444` and luma extraction functions.
- One sub-module `cam_pix_pack`: byte phase register plus format conversion, emits a pixel strobe; counters, decimation and the FSM stay in `cam_capture`.

## Test plan
- Reset mid-CAPT (after 100 pixels) → all outputs 0 next cycle, state IDLE, no writes.
- 640×480 RGB565 frame, DECIM = 1, bytes 0xF8,0x1F → 307200 writes of 0xF0F, last `wr_addr` = 307199, one `frame_done`, `frame_cnt` = 1, `err` = 0.
- DECIM = 2, same frame → 76800 writes, addresses 0..76799, only even pixels/lines.
- Line of 639 pixels then odd trailing byte → err[0] = 1, half pixel not written, next line starts at phase 0.
- `snap` with `enable` = 0 → exactly one frame written, then IDLE; second vsync cycle produces no writes.
- Frame of 500 lines with DECIM = 1, ADDR_W = 19 → lines 480–499 dropped, err[1] = 1, `wr_addr` never exceeds 307199.
